// File: rtl/cmp_tree_arbiter.sv
// Round-robin arbiter sharing one 64-bit comparator tree among NREQ requesters.
// Grant -> stage-1 operand registers -> stage-2 result registers -> tagged response.
module comparatortree64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  logic [7:0] byte_eq_s;
  logic [7:0] byte_lt_s;
  logic [3:0] eq1_s;
  logic [3:0] lt1_s;
  logic [1:0] eq2_s;
  logic [1:0] lt2_s;

  // Byte compares merged pairwise: the upper half decides unless it is equal.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      byte_eq_s[i] = (a[8*i +: 8] == b[8*i +: 8]);
      byte_lt_s[i] = (a[8*i +: 8] <  b[8*i +: 8]);
    end
    for (int j = 0; j < 4; j++) begin
      eq1_s[j] = byte_eq_s[2*j+1] & byte_eq_s[2*j];
      lt1_s[j] = byte_lt_s[2*j+1] | (byte_eq_s[2*j+1] & byte_lt_s[2*j]);
    end
    for (int j = 0; j < 2; j++) begin
      eq2_s[j] = eq1_s[2*j+1] & eq1_s[2*j];
      lt2_s[j] = lt1_s[2*j+1] | (eq1_s[2*j+1] & lt1_s[2*j]);
    end
    eq  = eq2_s[1] & eq2_s[0];
    ltu = lt2_s[1] | (eq2_s[1] & lt2_s[0]);
    lt  = (a[63] ^ b[63]) ? a[63] : ltu;
  end

endmodule

module cmp_tree_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_op1,
  input  logic [NREQ*64-1:0]   req_op2,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_eq,
  output logic                 resp_lt,
  output logic                 resp_ltu,
  output logic [NREQ-1:0]      pending
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic            s1_valid_q, s1_valid_d;
  logic [63:0]     s1_op1_q, s1_op1_d;
  logic [63:0]     s1_op2_q, s1_op2_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic            resp_eq_q, resp_eq_d;
  logic            resp_lt_q, resp_lt_d;
  logic            resp_ltu_q, resp_ltu_d;

  logic [NREQ-1:0] elig_s, grant_s, clr_s;
  logic [IDW-1:0]  idx_s, win_s;
  logic            take_s, found_s, accept_s;
  logic [63:0]     op1_sel_s, op2_sel_s;
  logic            tree_eq_s, tree_lt_s, tree_ltu_s;

  // Round-robin search starting at ptr; reset masks every grant.
  always_comb begin
    elig_s  = req_valid & ~pending_q;
    grant_s = {NREQ{1'b0}};
    win_s   = {IDW{1'b0}};
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    take_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s          = IDW'((int'(ptr_q) + k) % NREQ);
      take_s         = ~found_s & elig_s[idx_s];
      grant_s[idx_s] = grant_s[idx_s] | take_s;
      win_s          = take_s ? idx_s : win_s;
      found_s        = found_s | take_s;
    end
    grant_s   = reset ? {NREQ{1'b0}} : grant_s;
    req_ready = grant_s;
    accept_s  = |grant_s;
  end

  // Winner operand mux, pending bookkeeping and pipeline next state.
  always_comb begin
    op1_sel_s = 64'd0;
    op2_sel_s = 64'd0;
    clr_s     = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      op1_sel_s = op1_sel_s | ({64{grant_s[i]}} & req_op1[64*i +: 64]);
      op2_sel_s = op2_sel_s | ({64{grant_s[i]}} & req_op2[64*i +: 64]);
      clr_s[i]  = resp_valid_q & (resp_id_q == IDW'(i));
    end
    if (accept_s) begin
      ptr_d = (win_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : win_s + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
    // A fresh grant wins over a clear of the same bit.
    pending_d    = (pending_q & ~clr_s) | grant_s;
    s1_valid_d   = accept_s;
    s1_op1_d     = accept_s ? op1_sel_s : s1_op1_q;
    s1_op2_d     = accept_s ? op2_sel_s : s1_op2_q;
    s1_id_d      = accept_s ? win_s : s1_id_q;
    resp_valid_d = s1_valid_q;
    resp_id_d    = s1_id_q;
    resp_eq_d    = tree_eq_s;
    resp_lt_d    = tree_lt_s;
    resp_ltu_d   = tree_ltu_s;
  end

  comparatortree64 u_tree (
    .a   (s1_op1_q),
    .b   (s1_op2_q),
    .eq  (tree_eq_s),
    .lt  (tree_lt_s),
    .ltu (tree_ltu_s)
  );

  // Pipeline and arbitration state; reset discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= {IDW{1'b0}};
      pending_q    <= {NREQ{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_op1_q     <= 64'd0;
      s1_op2_q     <= 64'd0;
      s1_id_q      <= {IDW{1'b0}};
      resp_valid_q <= 1'b0;
      resp_id_q    <= {IDW{1'b0}};
      resp_eq_q    <= 1'b0;
      resp_lt_q    <= 1'b0;
      resp_ltu_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      s1_valid_q   <= s1_valid_d;
      s1_op1_q     <= s1_op1_d;
      s1_op2_q     <= s1_op2_d;
      s1_id_q      <= s1_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_eq_q    <= resp_eq_d;
      resp_lt_q    <= resp_lt_d;
      resp_ltu_q   <= resp_ltu_d;
    end
  end

  assign pending    = pending_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_eq    = resp_eq_q;
  assign resp_lt    = resp_lt_q;
  assign resp_ltu   = resp_ltu_q;

endmodule

// File: doc/cmp_tree_arbiter.md
# cmp_tree_arbiter

Round-robin arbiter that shares one `comparatortree64` instance among `NREQ` requesters. Each requester submits a 64-bit operand pair over a valid/ready handshake. The arbiter grants at most one request per cycle and pipelines the pair through a registered comparator stage. It returns EQ/LT/LTu on a shared response bus tagged with the requester ID. It sits between the integer-unit clients (branch resolve, min/max, set-less-than) and the single comparator tree.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: response ID width; derived, not overridden.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester grant; one-hot or zero.
- `req_op1`  in  NREQ*64: operand 1; requester i occupies bits [64i+63:64i].
- `req_op2`  in  NREQ*64: operand 2, same packing as `req_op1`.
- `resp_valid`  out  1: response valid for exactly one cycle; no backpressure.
- `resp_id`  out  IDW: index of the requester that owns the response.
- `resp_eq`  out  1: op1 == op2.
- `resp_lt`  out  1: op1 < op2, signed.
- `resp_ltu`  out  1: op1 < op2, unsigned.
- `pending`  out  NREQ: requester i has a request in flight.

## Operation
- Eligibility: `elig[i] = req_valid[i] & ~pending[i]`. Each requester has at most one outstanding request.
- Arbitration is combinational round-robin over `elig`.
  - The search starts at pointer `ptr` and wraps modulo NREQ.
  - `req_ready[i]` is high only for the single winner.
  - `req_ready` is all zero when `elig` is zero.
- Accept: `req_valid[i] & req_ready[i]` at a rising edge. On accept:
  - `ptr <= (i+1) mod NREQ`.
  - `pending[i] <= 1`.
  - Stage-1 registers load `op1`, `op2`, `id = i` and `s1_valid = 1`.
- With no accept, `ptr` holds and `s1_valid <= 0`.
- Stage 2: the comparator tree is driven from the stage-1 registers. Each edge loads `resp_eq/lt/ltu/id` from the tree and `resp_valid <= s1_valid`.
- `pending[i]` clears at the edge that ends a cycle where `resp_valid & (resp_id == i)`. Requester i is therefore ineligible during its own response cycle.
- Simultaneous set and clear of the same `pending` bit cannot occur, because a pending requester is ineligible. If it did occur, set wins.
- Requester rules:
  - Once `req_valid[i]` is asserted, it and the operands must stay stable until `req_ready[i]`.
  - Dropping valid before grant is a protocol violation; behaviour is undefined.
- Result fields are don't-care when `resp_valid = 0`. The RTL still registers them every cycle with no gating.
- Comparator semantics:
  - EQ is exact 64-bit equality.
  - LT is two's-complement signed.
  - LTu is unsigned.
  - If op1 == op2, then LT = LTu = 0.

## Timing
- Reset (asynchronous) values:
  - `ptr = 0`, `pending = 0`, `s1_valid = 0`.
  - `resp_valid = 0`, `resp_id = 0`, `resp_eq = resp_lt = resp_ltu = 0`.
  - `req_ready` therefore evaluates from `elig = 0` once reset asserts.
- `req_ready` is combinational from `req_valid`, `pending` and `ptr`, and is forced to 0 while `reset = 1`.
- Latency: accept at edge T, so `resp_valid = 1` in the cycle between edges T+1 and T+2.
- Same-requester reissue: earliest re-accept is at edge T+3, so one request per 3 cycles per requester.
- Aggregate throughput: one accept per cycle with 3 or more active requesters. Back-to-back accepts from different requesters produce back-to-back responses in grant order.
- Reset mid-operation:
  - In-flight stage-1 and stage-2 entries are discarded and no response is issued for them.
  - `pending` clears.
  - Requesters must re-present.
- Fairness: with all requesters continuously eligible, the grant order is 0,1,...,NREQ-1,0,...
- No requester waits more than NREQ-1 grants after becoming eligible.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with requester 2 in flight. All outputs must go 0 immediately, no `resp_valid` may follow, and `ptr` must be 0 after release.
- **Single request:** requester 1 sends op1 = 0xFFFFFFFFFFFFFFFF, op2 = 0x0000000000000001.
  - `req_ready[1]` must be high in the same cycle.
  - Two edges later: `resp_valid = 1`, `resp_id = 1`, eq = 0, lt = 1, ltu = 0.
- **All requesters valid continuously** (NREQ = 4):
  - Grants must follow 0,1,2,3, then wait for pending to clear, then resume at 0.
  - `resp_id` must follow the same sequence one response per cycle, with no grant to any requester while its `pending` bit is set.
- **Equality and sign boundary:**
  - op1 = op2 = 0x8000000000000000 must give eq = 1, lt = 0, ltu = 0.
  - op1 = 0x8000000000000000, op2 = 0x7FFFFFFFFFFFFFFF must give eq = 0, lt = 1, ltu = 0.
- **Pointer wrap and skip:** set `ptr = 3` via a grant to requester 2, then requesters 0 and 3 become valid in the same cycle. Requester 3 must be granted first and requester 0 on the next cycle.
- **Random regression:** 8192 random operand pairs spread over random requesters with random valid gaps. Each response must match a golden model for eq/lt/ltu and for ID order, with 0 errors.
